wgt_rd_responder: RTL and testbench

- Serves the weight read stream issued by the weight address controller. Each request is `read_en` high, with a byte-lane address `wgt_addr` and a lane count `read_wgt_size` (1..SYSTOLIC_SIZE); consecutive requests are usually contiguous but need not be line-aligned.
- Weight memory is two single-port banks of SYSTOLIC_SIZE-lane lines: even lines and odd lines. Both banks are read in the same cycle, so every request is served in one pass, aligned or not.
- The block realigns the returned data, zero-masks unused lanes and drives a SYSTOLIC_SIZE-lane weight vector into the systolic array's weight-load path.
- It applies no backpressure; one request per cycle is sustained.

---
 rtl/wgt_pkg.sv | 38 +++
 rtl/wgt_lane_align.sv | 30 +++
 rtl/wgt_rd_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_wgt_rd_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wgt_pkg.sv
// Shared definitions for the weight read responder.
//   SYSTOLIC_SIZE / DATA_WIDTH : lanes per line and bits per lane
//   WGT_RAM_SIZE_DEFAULT       : default total weight lanes
//   wgt_state_e                : responder FSM states (IDLE=0, STREAM=1, DRAIN=2)
//   clamp_size()               : maps a raw lane count onto 1..SYSTOLIC_SIZE
// Optional build macro: WGT_SKEW_EN (per-lane diagonal output skew).
package wgt_pkg;

  localparam int unsigned SYSTOLIC_SIZE        = 16;
  localparam int unsigned DATA_WIDTH           = 8;
  localparam int unsigned WGT_RAM_SIZE_DEFAULT = 8845488;
  localparam int unsigned OFF_W                = $clog2(SYSTOLIC_SIZE);
  localparam int unsigned SIZE_W               = 5;
  localparam int unsigned LINE_W               = SYSTOLIC_SIZE * DATA_WIDTH;

`ifdef WGT_SKEW_EN
  localparam int unsigned VALID_W      = SYSTOLIC_SIZE;
  localparam int unsigned DRAIN_CYCLES = 2 + SYSTOLIC_SIZE - 1;
`else
  localparam int unsigned VALID_W      = 1;
  localparam int unsigned DRAIN_CYCLES = 2;
`endif

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrain  = 2'd2
  } wgt_state_e;

  // Zero means a full line; anything wider than a line is cut to a full line.
  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] size);
    if (size == '0 || 32'(size) > SYSTOLIC_SIZE) begin
      return SIZE_W'(SYSTOLIC_SIZE);
    end
    return size;
  endfunction

endpackage

// File: rtl/wgt_lane_align.sv
// Purely combinational lane realignment.
//   line_lo / line_hi : the two consecutive memory lines, lower line first
//   off               : lane offset of the first requested lane within line_lo
//   size              : number of lanes to keep (lanes >= size are zeroed)
//   vec               : realigned, masked vector, lane 0 in the LSBs
module wgt_lane_align
  import wgt_pkg::*;
(
  input  logic [LINE_W-1:0] line_lo,
  input  logic [LINE_W-1:0] line_hi,
  input  logic [OFF_W-1:0]  off,
  input  logic [SIZE_W-1:0] size,
  output logic [LINE_W-1:0] vec
);

  logic [2*LINE_W-1:0] both;
  logic [LINE_W-1:0]   shifted;

  always_comb begin
    both    = {line_hi, line_lo};
    shifted = LINE_W'(both >> (32'(off) * DATA_WIDTH));
    vec     = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      if (32'(i) < 32'(size)) begin
        vec[i*DATA_WIDTH +: DATA_WIDTH] = shifted[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/wgt_rd_responder.sv
// Weight read responder: turns (wgt_addr, read_wgt_size) requests into
// realigned SYSTOLIC_SIZE-lane weight vectors, two cycles after read_en.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   read_en, wgt_addr, read_wgt_size : request (one per cycle, no backpressure)
//   mem_rd_en, mem_even_addr, mem_odd_addr : common strobe + per-bank line address
//   mem_even_rdata, mem_odd_rdata  : bank data, one cycle after the strobe
//   wgt_data, wgt_valid, wgt_last  : realigned weights and beat framing
//   beat_cnt                       : beats delivered in the current burst
//   oob_err                        : sticky out-of-range request flag
// Optional build macro: WGT_SKEW_EN delays lane i by i extra cycles and widens
// wgt_valid to one bit per lane.
module wgt_rd_responder
  import wgt_pkg::*;
#(
  parameter int unsigned WGT_RAM_SIZE = WGT_RAM_SIZE_DEFAULT,
  localparam int unsigned AW          = $clog2(WGT_RAM_SIZE),
  localparam int unsigned LINE_AW     = $clog2(WGT_RAM_SIZE / SYSTOLIC_SIZE / 2 + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read_en,
  input  logic [AW-1:0]      wgt_addr,
  input  logic [SIZE_W-1:0]  read_wgt_size,
  output logic               mem_rd_en,
  output logic [LINE_AW-1:0] mem_even_addr,
  output logic [LINE_AW-1:0] mem_odd_addr,
  input  logic [LINE_W-1:0]  mem_even_rdata,
  input  logic [LINE_W-1:0]  mem_odd_rdata,
  output logic [LINE_W-1:0]  wgt_data,
  output logic [VALID_W-1:0] wgt_valid,
  output logic               wgt_last,
  output logic [12:0]        beat_cnt,
  output logic               oob_err
);

  localparam int unsigned LW = AW - OFF_W;

  // ---------------------------------------------------------------- stage 0
  logic [LW-1:0]     line_idx;
  logic [LW:0]       line_next;
  logic [SIZE_W-1:0] size_c;
  logic              oob_set;

  assign line_idx  = wgt_addr[AW-1:OFF_W];
  assign line_next = {1'b0, line_idx} + (LW + 1)'(1);
  assign size_c    = clamp_size(read_wgt_size);
  assign oob_set   = read_en && ((32'(wgt_addr) + 32'(size_c)) > WGT_RAM_SIZE);

  // Even bank holds lines 2k, odd bank lines 2k+1: lines L and L+1 always
  // land in different banks, so both are fetched in the same cycle.
  assign mem_rd_en     = read_en & rst_n;
  assign mem_even_addr = rst_n ? LINE_AW'(line_next >> 1) : '0;
  assign mem_odd_addr  = rst_n ? LINE_AW'(line_idx >> 1) : '0;

  logic              s1_vld_q;
  logic              s1_odd_q;
  logic [OFF_W-1:0]  s1_off_q;
  logic [SIZE_W-1:0] s1_size_q;
  logic [AW-1:0]     s1_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_odd_q  <= 1'b0;
      s1_off_q  <= '0;
      s1_size_q <= '0;
      s1_addr_q <= '0;
    end else begin
      s1_vld_q <= read_en;
      if (read_en) begin
        s1_odd_q  <= line_idx[0];
        s1_off_q  <= wgt_addr[OFF_W-1:0];
        s1_size_q <= size_c;
        s1_addr_q <= wgt_addr;
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [LINE_W-1:0] line_lo;
  logic [LINE_W-1:0] line_hi;
  logic [LINE_W-1:0] aligned;
  logic [31:0]       addr_ext;
  logic [31:0]       room;
  logic [SIZE_W-1:0] eff_size;

  assign line_lo = s1_odd_q ? mem_odd_rdata : mem_even_rdata;
  assign line_hi = s1_odd_q ? mem_even_rdata : mem_odd_rdata;

  // Lanes past the end of memory are masked by shrinking the lane count.
  always_comb begin
    addr_ext = 32'(s1_addr_q);
    room     = (addr_ext < WGT_RAM_SIZE) ? (WGT_RAM_SIZE - addr_ext) : 32'd0;
    eff_size = (room < 32'(s1_size_q)) ? SIZE_W'(room) : s1_size_q;
  end

  wgt_lane_align u_align (
    .line_lo (line_lo),
    .line_hi (line_hi),
    .off     (s1_off_q),
    .size    (eff_size),
    .vec     (aligned)
  );

  // ---------------------------------------------------------------- FSM
  wgt_state_e state_q, state_d;
  logic [4:0] drain_q, drain_d;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (read_en) state_d = StStream;
      end
      StStream: begin
        if (!read_en) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        if (read_en) begin
          state_d = StStream;
        end else if (drain_q == 5'(DRAIN_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          drain_d = drain_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------- output stage
  logic              out_vld_q;
  logic              out_last_q;
  logic [LINE_W-1:0] data_q;
  logic [12:0]       cnt_q, cnt_d;
  logic              reload_q;
  logic              oob_q;
  logic              last_d;

  // read_en of the following cycle is visible while this beat sits in stage 1.
  assign last_d = s1_vld_q & ~read_en;

  always_comb begin
    cnt_d = cnt_q;
    if (s1_vld_q && state_q != StIdle) begin
      if (reload_q) begin
        cnt_d = 13'd1;
      end else if (cnt_q != 13'h1fff) begin
        cnt_d = cnt_q + 13'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      drain_q    <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      reload_q   <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      out_vld_q  <= s1_vld_q;
      out_last_q <= last_d;
      cnt_q      <= cnt_d;
      if (s1_vld_q) begin
        data_q   <= aligned;
        reload_q <= last_d;
      end
      if (oob_set) oob_q <= 1'b1;
    end
  end

  assign beat_cnt = cnt_q;
  assign oob_err  = oob_q;

`ifdef WGT_SKEW_EN
  for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign wgt_data[0 +: DATA_WIDTH] = data_q[0 +: DATA_WIDTH];
      assign wgt_valid[0]              = out_vld_q;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] d_sr [i];
      logic [i-1:0]          v_sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) d_sr[k] <= '0;
          v_sr <= '0;
        end else begin
          d_sr[0] <= data_q[i*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < i; k++) d_sr[k] <= d_sr[k-1];
          v_sr <= i'({v_sr, out_vld_q});
        end
      end
      assign wgt_data[i*DATA_WIDTH +: DATA_WIDTH] = d_sr[i-1];
      assign wgt_valid[i]                         = v_sr[i-1];
    end
  end

  // Burst end is flagged together with the most delayed lane.
  logic [SYSTOLIC_SIZE-2:0] last_sr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sr <= '0;
    end else begin
      last_sr <= {last_sr[SYSTOLIC_SIZE-3:0], out_last_q};
    end
  end
  assign wgt_last = last_sr[SYSTOLIC_SIZE-2];
`else
  assign wgt_data  = data_q;
  assign wgt_valid = out_vld_q;
  assign wgt_last  = out_last_q;
`endif

endmodule

// File: tb/tb_wgt_rd_responder.sv
module tb_wgt_rd_responder;
  import wgt_pkg::*;

  localparam int unsigned RAM     = WGT_RAM_SIZE_DEFAULT;
  localparam int unsigned AW      = $clog2(RAM);
  localparam int unsigned LINE_AW = $clog2(RAM / SYSTOLIC_SIZE / 2 + 1);
  localparam int unsigned LW      = SYSTOLIC_SIZE * DATA_WIDTH;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               read_en = 1'b0;
  logic [AW-1:0]      wgt_addr = '0;
  logic [4:0]         read_wgt_size = '0;
  logic               mem_rd_en;
  logic [LINE_AW-1:0] mem_even_addr;
  logic [LINE_AW-1:0] mem_odd_addr;
  logic [LW-1:0]      mem_even_rdata = '0;
  logic [LW-1:0]      mem_odd_rdata = '0;
  logic [LW-1:0]      wgt_data;
  logic [VALID_W-1:0] wgt_valid;
  logic               wgt_last;
  logic [12:0]        beat_cnt;
  logic               oob_err;

  int n_run = 0;
  int n_fail = 0;

  wgt_rd_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_en        (read_en),
    .wgt_addr       (wgt_addr),
    .read_wgt_size  (read_wgt_size),
    .mem_rd_en      (mem_rd_en),
    .mem_even_addr  (mem_even_addr),
    .mem_odd_addr   (mem_odd_addr),
    .mem_even_rdata (mem_even_rdata),
    .mem_odd_rdata  (mem_odd_rdata),
    .wgt_data       (wgt_data),
    .wgt_valid      (wgt_valid),
    .wgt_last       (wgt_last),
    .beat_cnt       (beat_cnt),
    .oob_err        (oob_err)
  );

  always #5 clk = ~clk;

  // Weight at absolute lane address a.
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [LW-1:0] line_bits(input logic [31:0] line);
    logic [LW-1:0] v;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      v[i*DATA_WIDTH +: DATA_WIDTH] = byte_at(line * SYSTOLIC_SIZE + 32'(i));
    end
    return v;
  endfunction

  // Bank memories: even bank word k = line 2k, odd bank word k = line 2k+1.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_even_rdata <= line_bits(32'(mem_even_addr) * 2);
      mem_odd_rdata  <= line_bits(32'(mem_odd_addr) * 2 + 1);
    end
  end

  function automatic int unsigned lanes_of(input int unsigned size);
    return (size == 0 || size > SYSTOLIC_SIZE) ? SYSTOLIC_SIZE : size;
  endfunction

  // Expected vector straight from absolute lane addresses.
  function automatic logic [LW-1:0] exp_vec(input int unsigned addr, input int unsigned size);
    logic [LW-1:0] v = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      if (32'(i) < lanes_of(size) && addr + 32'(i) < RAM) begin
        v[i*DATA_WIDTH +: DATA_WIDTH] = byte_at(addr + 32'(i));
      end
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model state: requests of the previous two cycles, burst counter, sticky flag.
  bit          h1_en = 0, h2_en = 0;
  int unsigned h1_addr = 0, h2_addr = 0, h1_size = 0, h2_size = 0;
  int unsigned m_cnt = 0;
  bit          m_prev_last = 0;
  bit          m_oob = 0;

  task automatic model_check();
    int unsigned cur_addr, ln, even_line, odd_line;
    bit exp_last;
    cur_addr = 32'(wgt_addr);
    if (!rst_n) begin
      chk("rst_mem", LW'({mem_rd_en, mem_even_addr, mem_odd_addr}), '0);
      chk("rst_data", wgt_data, '0);
      chk("rst_flags", LW'({wgt_valid, wgt_last, beat_cnt, oob_err}), '0);
      h1_en = 0; h2_en = 0; m_cnt = 0; m_prev_last = 0; m_oob = 0;
    end else begin
      chk("mem_rd_en", LW'(mem_rd_en), LW'(read_en));
      if (read_en) begin
        ln        = cur_addr / SYSTOLIC_SIZE;
        even_line = (ln % 2 == 0) ? ln : ln + 1;
        odd_line  = (ln % 2 == 1) ? ln : ln + 1;
        chk("mem_even_addr", LW'(mem_even_addr), LW'(LINE_AW'(even_line / 2)));
        chk("mem_odd_addr", LW'(mem_odd_addr), LW'(LINE_AW'((odd_line - 1) / 2)));
      end
      exp_last = h2_en && !h1_en;
      if (h2_en) begin
        m_cnt       = m_prev_last ? 1 : ((m_cnt == 8191) ? 8191 : m_cnt + 1);
        m_prev_last = exp_last;
        chk("wgt_data", wgt_data, exp_vec(h2_addr, h2_size));
      end
      chk("wgt_valid", LW'(wgt_valid), LW'(h2_en));
      chk("wgt_last", LW'(wgt_last), LW'(exp_last));
      chk("beat_cnt", LW'(beat_cnt), LW'(m_cnt));
      chk("oob_err", LW'(oob_err), LW'(m_oob));
      if (read_en && cur_addr + lanes_of(32'(read_wgt_size)) > RAM) m_oob = 1;
      h2_en = h1_en; h2_addr = h1_addr; h2_size = h1_size;
      h1_en = read_en; h1_addr = cur_addr; h1_size = 32'(read_wgt_size);
    end
  endtask

  task automatic tick(input logic en, input int unsigned addr, input int unsigned size,
                      input logic rst = 1'b1);
    @(posedge clk);
    #1;
    rst_n         = rst;
    read_en       = en;
    wgt_addr      = AW'(addr);
    read_wgt_size = 5'(size);
    @(negedge clk);
    model_check();
  endtask

  function automatic logic [7:0] lane(input int i);
    return wgt_data[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  initial begin
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0);
    chk("pin_idle_valid", LW'(wgt_valid), '0);

    // Aligned 3-beat burst.
    tick(1, 0, 16);
    chk("pin_al_even0", LW'(mem_even_addr), 0);
    chk("pin_al_odd0", LW'(mem_odd_addr), 0);
    tick(1, 16, 16);
    chk("pin_al_even1", LW'(mem_even_addr), 1);
    chk("pin_al_odd1", LW'(mem_odd_addr), 0);
    tick(1, 32, 16);
    chk("pin_al_even2", LW'(mem_even_addr), 1);
    chk("pin_al_odd2", LW'(mem_odd_addr), 1);
    chk("pin_al_beat1_lane0", LW'(lane(0)), 8'hA5);
    chk("pin_al_beat1_cnt", LW'(beat_cnt), 1);
    tick(0, 0, 0);
    chk("pin_al_beat2_lane0", LW'(lane(0)), 8'hB5);
    tick(0, 0, 0);
    chk("pin_al_beat3_lane0", LW'(lane(0)), 8'h85);
    chk("pin_al_last", LW'(wgt_last), 1);
    chk("pin_al_cnt", LW'(beat_cnt), 3);

    // Unaligned single beat.
    tick(1, 15, 16);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("pin_un_lane0", LW'(lane(0)), 8'hAA);
    chk("pin_un_lane1", LW'(lane(1)), 8'hB5);
    chk("pin_un_lane15", LW'(lane(15)), 8'hBB);
    chk("pin_un_last", LW'({wgt_valid, wgt_last}), 2'b11);
    chk("pin_un_cnt", LW'(beat_cnt), 1);

    // Partial line, then an unaligned follow-on.
    tick(1, 32, 15);
    tick(1, 47, 16);
    chk("pin_47_even", LW'(mem_even_addr), 1);
    chk("pin_47_odd", LW'(mem_odd_addr), 1);
    tick(0, 0, 0);
    chk("pin_p15_lane14", LW'(lane(14)), 8'h8B);
    chk("pin_p15_lane15", LW'(lane(15)), 8'h00);
    tick(0, 0, 0);
    chk("pin_47_lane0", LW'(lane(0)), 8'h8A);

    // Size 0 / oversize / short sizes.
    tick(1, 3, 5);
    tick(1, 64, 0);
    tick(1, 80, 31);
    chk("pin_s5_lane4", LW'(lane(4)), 8'hA2);
    chk("pin_s5_lane5", LW'(lane(5)), 8'h00);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);

    // End-of-memory boundary.
    chk("pin_oob_clear", LW'(oob_err), 0);
    tick(1, RAM - 4, 16);
    chk("pin_bd_even", LW'(mem_even_addr), 276421);
    chk("pin_bd_odd", LW'(mem_odd_addr), 276421);
    tick(0, 0, 0);
    chk("pin_oob_set", LW'(oob_err), 1);
    tick(0, 0, 0);
    chk("pin_bd_lane3", LW'(lane(3)), 8'h0A);
    chk("pin_bd_lane4", LW'(lane(4)), 8'h00);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("pin_oob_held", LW'(oob_err), 1);

    // Reset in the middle of a 5-beat burst.
    tick(1, 0, 16);
    tick(1, 16, 16);
    tick(1, 32, 16);
    tick(1, 48, 16, 0);
    chk("pin_rst_valid", LW'(wgt_valid), 0);
    chk("pin_rst_oob", LW'(oob_err), 0);
    chk("pin_rst_rd_en", LW'(mem_rd_en), 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("pin_rst_after", LW'(wgt_valid), 0);

    // Back-to-back 2-beat bursts with a one-cycle gap.
    tick(1, 0, 16);
    tick(1, 16, 16);
    tick(0, 0, 0);
    chk("pin_bb_cnt1", LW'({wgt_last, beat_cnt}), LW'({1'b0, 13'd1}));
    tick(1, 32, 16);
    chk("pin_bb_cnt2", LW'({wgt_last, beat_cnt}), LW'({1'b1, 13'd2}));
    tick(1, 48, 16);
    tick(0, 0, 0);
    chk("pin_bb_cnt3", LW'({wgt_last, beat_cnt}), LW'({1'b0, 13'd1}));
    tick(0, 0, 0);
    chk("pin_bb_cnt4", LW'({wgt_last, beat_cnt}), LW'({1'b1, 13'd2}));
    tick(0, 0, 0);
    tick(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
